// File: rtl/msg_counter_pkg.sv
// msg_counter_pkg: shared state encoding and default parameter values for msg_counter.
`default_nettype none
`timescale 1ns/1ps

package msg_counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2
  } msg_state_e;

  localparam int DEF_MSG_LEN   = 3;
  localparam int DEF_MSG_CNT_W = 8;
  localparam int DEF_TIMEOUT   = 16;

endpackage

`default_nettype wire

// File: rtl/msg_counter_if.sv
// msg_counter_if: symbol/ack inputs and message status outputs between front-end, counter and consumer.
`default_nettype none
`timescale 1ns/1ps

interface msg_counter_if #(
  parameter int MSG_LEN   = msg_counter_pkg::DEF_MSG_LEN,
  parameter int MSG_CNT_W = msg_counter_pkg::DEF_MSG_CNT_W
);
  localparam int SYM_W = $clog2(MSG_LEN + 1);

  logic                 sym_en;
  logic                 clr;
  logic                 msg_ack;
  logic                 msg_rdy;
  logic [SYM_W-1:0]     sym_cnt;
  logic [MSG_CNT_W-1:0] msg_cnt;
  logic                 ovf;
  logic                 msg_abort;

  modport master (
    output sym_en, clr, msg_ack,
    input  msg_rdy, sym_cnt, msg_cnt, ovf, msg_abort
  );

  modport slave (
    input  sym_en, clr, msg_ack,
    output msg_rdy, sym_cnt, msg_cnt, ovf, msg_abort
  );

endinterface

`default_nettype wire

// File: rtl/msg_counter_timer.sv
// msg_timeout_timer: reloadable down-counter; o_expire flags TIMEOUT consecutive cycles without i_load.
`default_nettype none
`timescale 1ns/1ps

module msg_timeout_timer #(
  parameter int TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_load,
  output logic      o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] c_reload = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] c_one    = CW'(1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= c_reload;
    end else if (i_load) begin
      r_cnt <= c_reload;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  // The expiry cycle is the TIMEOUT-th idle one, so a strobe on it still wins.
  assign o_expire = !i_load && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/msg_counter.sv
// msg_counter: collects MSG_LEN symbol strobes into a message held until acknowledged.
// Optional idle abort in COLLECT is built when MSG_TIMEOUT_EN is defined.
`default_nettype none
`timescale 1ns/1ps

module msg_counter
  import msg_counter_pkg::*;
#(
  parameter int MSG_LEN   = DEF_MSG_LEN,
  parameter int MSG_CNT_W = DEF_MSG_CNT_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  wire logic      count,
  input  wire logic      rst,
  msg_counter_if.slave   bus
);

  localparam int SYM_W = $clog2(MSG_LEN + 1);
  localparam logic [SYM_W-1:0]     c_msg_len  = SYM_W'(MSG_LEN);
  localparam logic [SYM_W-1:0]     c_sym_one  = SYM_W'(1);
  localparam logic [MSG_CNT_W-1:0] c_msg_one  = MSG_CNT_W'(1);
  localparam msg_state_e           c_first_st = (MSG_LEN == 1) ? READY : COLLECT;

  generate
    if (MSG_LEN < 1 || MSG_LEN > 255 || TIMEOUT < 1) begin : g_param_range_invalid
      // Empty marker scope: its presence in the hierarchy exposes an illegal configuration.
    end
  endgenerate

  msg_state_e           r_state, w_state;
  logic [SYM_W-1:0]     r_sym_cnt, w_sym_cnt;
  logic [MSG_CNT_W-1:0] r_msg_cnt, w_msg_cnt;
  logic                 r_ovf, w_ovf;
  logic                 r_abort, w_abort;
  logic                 r_msg_rdy;
  logic                 w_tmr_expire;

`ifdef MSG_TIMEOUT_EN
  logic w_tmr_load;

  // Held at reload outside COLLECT, so entering COLLECT always starts a fresh window.
  assign w_tmr_load = (r_state != COLLECT) || bus.sym_en;

  msg_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (count),
    .rst_n    (rst),
    .i_load   (w_tmr_load),
    .o_expire (w_tmr_expire)
  );
`else
  assign w_tmr_expire = 1'b0;
`endif

  always_comb begin
    w_state   = r_state;
    w_sym_cnt = r_sym_cnt;
    w_msg_cnt = r_msg_cnt;
    w_ovf     = r_ovf;
    w_abort   = 1'b0;

    if (bus.clr) begin
      w_state   = IDLE;
      w_sym_cnt = '0;
      w_msg_cnt = '0;
      w_ovf     = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.sym_en) begin
            w_state   = c_first_st;
            w_sym_cnt = c_sym_one;
          end
        end
        COLLECT: begin
          if (bus.sym_en) begin
            w_sym_cnt = r_sym_cnt + c_sym_one;
            if (w_sym_cnt == c_msg_len) begin
              w_state = READY;
            end
          end else if (w_tmr_expire) begin
            w_state   = IDLE;
            w_sym_cnt = '0;
            w_abort   = 1'b1;
          end
        end
        READY: begin
          if (bus.msg_ack) begin
            w_msg_cnt = r_msg_cnt + c_msg_one;
            if (bus.sym_en) begin
              // The coincident symbol opens the next message rather than overflowing.
              w_state   = c_first_st;
              w_sym_cnt = c_sym_one;
            end else begin
              w_state   = IDLE;
              w_sym_cnt = '0;
            end
          end else if (bus.sym_en) begin
            w_ovf = 1'b1;
          end
        end
        default: begin
          w_state   = IDLE;
          w_sym_cnt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge count or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_sym_cnt <= '0;
      r_msg_cnt <= '0;
      r_ovf     <= 1'b0;
      r_abort   <= 1'b0;
      r_msg_rdy <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_sym_cnt <= w_sym_cnt;
      r_msg_cnt <= w_msg_cnt;
      r_ovf     <= w_ovf;
      r_abort   <= w_abort;
      r_msg_rdy <= (w_state == READY);
    end
  end

  assign bus.msg_rdy   = r_msg_rdy;
  assign bus.sym_cnt   = r_sym_cnt;
  assign bus.msg_cnt   = r_msg_cnt;
  assign bus.ovf       = r_ovf;
  assign bus.msg_abort = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_msg_counter.sv
// tb_msg_counter: scoreboard bench for msg_counter (MSG_LEN=3/MSG_CNT_W=2 and MSG_LEN=1 instances).
`default_nettype none
`timescale 1ns/1ps

module tb_msg_counter;

  logic count;
  logic rst;

  msg_counter_if #(.MSG_LEN(3), .MSG_CNT_W(2)) if_a ();
  msg_counter_if #(.MSG_LEN(1), .MSG_CNT_W(8)) if_b ();

  msg_counter #(.MSG_LEN(3), .MSG_CNT_W(2), .TIMEOUT(4)) u_dut_a (
    .count (count),
    .rst   (rst),
    .bus   (if_a.slave)
  );

  msg_counter #(.MSG_LEN(1), .MSG_CNT_W(8), .TIMEOUT(4)) u_dut_b (
    .count (count),
    .rst   (rst),
    .bus   (if_b.slave)
  );

  initial count = 1'b0;
  always #5 count = ~count;

  typedef struct {
    bit    sel;
    string name;
    int    rdy;
    int    sym;
    int    msg;
    int    ovf;
    int    abort;
  } exp_t;

  exp_t q[$];
  event mon_ev;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Monitor: pops every queued expectation once the stimulus side signals a sample point.
  always begin
    @(mon_ev);
    while (q.size() > 0) begin
      exp_t e;
      int ar, as, am, ao, aa;
      e = q.pop_front();
      if (e.sel == 1'b0) begin
        ar = int'(if_a.msg_rdy); as = int'(if_a.sym_cnt); am = int'(if_a.msg_cnt);
        ao = int'(if_a.ovf);     aa = int'(if_a.msg_abort);
      end else begin
        ar = int'(if_b.msg_rdy); as = int'(if_b.sym_cnt); am = int'(if_b.msg_cnt);
        ao = int'(if_b.ovf);     aa = int'(if_b.msg_abort);
      end
      n_cmp++;
      if (ar != e.rdy || as != e.sym || am != e.msg || ao != e.ovf || aa != e.abort) begin
        n_fail++;
        $display("FAIL %s (dut %0d): got rdy=%0d sym=%0d msg=%0d ovf=%0d abort=%0d, want rdy=%0d sym=%0d msg=%0d ovf=%0d abort=%0d",
                 e.name, e.sel, ar, as, am, ao, aa, e.rdy, e.sym, e.msg, e.ovf, e.abort);
      end
    end
  end

  task automatic expect_now(input bit sel, input string nm,
                            input int er, input int es, input int em, input int eo, input int ea);
    exp_t e;
    e.sel = sel; e.name = nm; e.rdy = er; e.sym = es; e.msg = em; e.ovf = eo; e.abort = ea;
    q.push_back(e);
    -> mon_ev;
  endtask

  task automatic drive(input bit sel, input bit en, input bit ack, input bit c);
    if_a.sym_en = 1'b0; if_a.msg_ack = 1'b0; if_a.clr = 1'b0;
    if_b.sym_en = 1'b0; if_b.msg_ack = 1'b0; if_b.clr = 1'b0;
    if (sel == 1'b0) begin
      if_a.sym_en = en; if_a.msg_ack = ack; if_a.clr = c;
    end else begin
      if_b.sym_en = en; if_b.msg_ack = ack; if_b.clr = c;
    end
  endtask

  // One clock of stimulus; the expectation describes outputs after that edge.
  task automatic cyc(input bit sel, input bit en, input bit ack, input bit c, input string nm,
                     input int er, input int es, input int em, input int eo, input int ea);
    @(negedge count);
    drive(sel, en, ack, c);
    @(posedge count);
    #1;
    expect_now(sel, nm, er, es, em, eo, ea);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    expect_now(1'b0, "reset_a", 0, 0, 0, 0, 0);
    expect_now(1'b1, "reset_b", 0, 0, 0, 0, 0);
    @(negedge count);
    rst = 1'b1;

    // Basic message and acknowledge
    cyc(0, 1, 0, 0, "basic_s1",  0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, "basic_s2",  0, 2, 0, 0, 0);
    cyc(0, 1, 0, 0, "basic_s3",  1, 3, 0, 0, 0);
    cyc(0, 0, 1, 0, "basic_ack", 0, 0, 1, 0, 0);

    // Overflow while READY, then clear
    cyc(0, 1, 0, 0, "ovf_s1",   0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, "ovf_s2",   0, 2, 1, 0, 0);
    cyc(0, 1, 0, 0, "ovf_s3",   1, 3, 1, 0, 0);
    cyc(0, 1, 0, 0, "ovf_drop1", 1, 3, 1, 1, 0);
    cyc(0, 1, 0, 0, "ovf_drop2", 1, 3, 1, 1, 0);
    cyc(0, 0, 0, 0, "ovf_sticky", 1, 3, 1, 1, 0);
    cyc(0, 0, 0, 1, "ovf_clr",  0, 0, 0, 0, 0);

    // Ack and strobe together
    cyc(0, 1, 0, 0, "ackEn_s1", 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, "ackEn_s2", 0, 2, 0, 0, 0);
    cyc(0, 1, 0, 0, "ackEn_s3", 1, 3, 0, 0, 0);
    cyc(0, 1, 1, 0, "ackEn_both", 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, "ackEn_s2b", 0, 2, 1, 0, 0);
    cyc(0, 1, 0, 0, "ackEn_s3b", 1, 3, 1, 0, 0);
    cyc(0, 0, 1, 0, "ackEn_ack", 0, 0, 2, 0, 0);
    cyc(0, 0, 1, 0, "ack_idle_ignored", 0, 0, 2, 0, 0);

    // clr beats concurrent ack and strobe
    cyc(0, 1, 0, 0, "clrpri_s1", 0, 1, 2, 0, 0);
    cyc(0, 1, 0, 0, "clrpri_s2", 0, 2, 2, 0, 0);
    cyc(0, 1, 0, 0, "clrpri_s3", 1, 3, 2, 0, 0);
    cyc(0, 1, 1, 1, "clrpri_clr", 0, 0, 0, 0, 0);

    // COLLECT holds across idle cycles; ack in COLLECT ignored
    cyc(0, 1, 0, 0, "hold_s1",   0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, "hold_i1",   0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, "hold_ack",  0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, "hold_s2",   0, 2, 0, 0, 0);
    cyc(0, 1, 0, 0, "hold_s3",   1, 3, 0, 0, 0);
    cyc(0, 0, 1, 0, "hold_done", 0, 0, 1, 0, 0);

    // msg_cnt wraps at 2 bits: 1,2,3,0,1
    cyc(0, 0, 0, 1, "wrap_clr", 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 0, 0, "wrap_s1",  0, 1, (k - 1) % 4, 0, 0);
      cyc(0, 1, 0, 0, "wrap_s2",  0, 2, (k - 1) % 4, 0, 0);
      cyc(0, 1, 0, 0, "wrap_s3",  1, 3, (k - 1) % 4, 0, 0);
      cyc(0, 0, 1, 0, "wrap_ack", 0, 0, k % 4, 0, 0);
    end

    // MSG_LEN = 1 instance
    cyc(1, 1, 0, 0, "len1_s1",     1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, "len1_ackEn",  1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, "len1_ack",    0, 0, 2, 0, 0);
    cyc(1, 1, 0, 0, "len1_s2",     1, 1, 2, 0, 0);
    cyc(1, 1, 0, 0, "len1_ovf",    1, 1, 2, 1, 0);

    // Asynchronous reset mid-message
    cyc(0, 1, 0, 0, "arst_s1", 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, "arst_s2", 0, 2, 1, 0, 0);
    @(negedge count);
    drive(0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    expect_now(0, "arst_async", 0, 0, 0, 0, 0);
    @(negedge count);
    rst = 1'b1;
    cyc(0, 1, 0, 0, "arst_n1", 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, "arst_n2", 0, 2, 0, 0, 0);
    cyc(0, 1, 0, 0, "arst_n3", 1, 3, 0, 0, 0);
    cyc(0, 0, 1, 0, "arst_ack", 0, 0, 1, 0, 0);

    // Idle timeout in COLLECT (TIMEOUT = 4)
    cyc(0, 0, 0, 1, "to_clr", 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, "to_s1",  0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, "to_i1",  0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, "to_i2",  0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, "to_i3",  0, 1, 0, 0, 0);
`ifdef MSG_TIMEOUT_EN
    cyc(0, 0, 0, 0, "to_i4_abort", 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, "to_after",    0, 0, 0, 0, 0);
`else
    cyc(0, 0, 0, 0, "to_i4_hold",  0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, "to_after",    0, 1, 0, 0, 0);
`endif
    cyc(0, 0, 0, 1, "to_clr2", 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, "to2_s1",  0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, "to2_i1",  0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, "to2_i2",  0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, "to2_i3",  0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, "to2_s_on_expiry", 0, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, "to2_after", 0, 2, 0, 0, 0);

    @(negedge count);
    drive(0, 0, 0, 0);
    repeat (2) @(posedge count);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
